serial_adder_subtractor: RTL and testbench

SERIAL_ADDER_SUBTRACTOR -- requirements
Module: serial_adder_subtractor

---
 rtl/serial_adder_subtractor_if.sv | 26 ++
 rtl/serial_adder_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_adder_subtractor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_subtractor_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The master drives operands and start; the slave returns result, flags and status.
interface serial_adder_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, control, a, b, cin,
        input  result, cout, busy, done, overflow
    );

    modport slave (
        input  start, control, a, b, cin,
        output result, cout, busy, done, overflow
    );
endinterface

// File: rtl/serial_adder_subtractor.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell, LSB first, WIDTH cycles per operation.
// Define OVERFLOW_DETECT_EN to build the signed-overflow flag; otherwise overflow is tied to 0.
module serial_adder_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    serial_adder_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               sub_q, sub_d;
`ifdef OVERFLOW_DETECT_EN
    logic               ovf_q, ovf_d;
`endif

    logic bit_a, bit_b, sum_bit, carry_bit, last_bit, accept;

    // Shared cell: the sum/difference bit is the same XOR; only carry vs borrow differs.
    always_comb begin
        bit_a   = a_q[0];
        bit_b   = b_q[0];
        sum_bit = bit_a ^ bit_b ^ carry_q;
        if (sub_q) begin
            carry_bit = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & carry_q);
        end else begin
            carry_bit = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
        end
    end

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        // NOTE: every _d takes its _q first, so no path through this block can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sub_d    = sub_q;
`ifdef OVERFLOW_DETECT_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.control;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_bit;
                acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d  = DONE;
                    result_d = {sum_bit, acc_q[WIDTH-1:1]};
                    cout_d   = carry_bit;
`ifdef OVERFLOW_DETECT_EN
                    // On the last bit a_q[0]/b_q[0] hold the original operand sign bits.
                    ovf_d    = (bit_a == (bit_b ^ sub_q)) && (sum_bit != bit_a);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef OVERFLOW_DETECT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // NOTE: operand/accumulator shift registers are always reloaded on start, so they carry no reset.
    always_ff @(posedge clk_i) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        sub_q <= sub_d;
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
`ifdef OVERFLOW_DETECT_EN
    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed bench for serial_adder_subtractor (WIDTH=8): vector table plus hand-written
// sequences for start-during-run, back-to-back start and mid-run reset.
module tb_serial_adder_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_adder_subtractor_if #(.WIDTH(W)) bus ();

    serial_adder_subtractor #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t         vecs[11];
    logic [W-1:0] held_res;
    logic         held_cout;
    logic         held_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic ovf_exp(input logic v);
`ifdef OVERFLOW_DETECT_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        bus.start   = s;
        bus.control = c;
        bus.a       = a;
        bus.b       = b;
        bus.cin     = ci;
    endtask

    // Issues start at the next edge, then scrambles the inputs to show they are ignored.
    task automatic launch(input logic c, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        drive(1'b1, c, a, b, ci);
        tick();
        drive(1'b0, ~c, ~a, a ^ b, ~ci);
    endtask

    task automatic check_busy_cycle(input string tag, input int c);
        check($sformatf("%s_busy_c%0d", tag, c), bus.busy, 1);
        check($sformatf("%s_done_c%0d", tag, c), bus.done, 0);
        check($sformatf("%s_hold_c%0d", tag, c), bus.result, held_res);
    endtask

    task automatic check_done(input string tag, input logic [W-1:0] r, input logic co, input logic ov);
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_result"}, bus.result, r);
        check({tag, "_cout"}, bus.cout, co);
        check({tag, "_ovf"}, bus.overflow, ovf_exp(ov));
        held_res  = r;
        held_cout = co;
        held_ovf  = ov;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'd5,   8'd9,   1'b0, 8'hFC,  1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'd0,   8'd0,   1'b1, 8'hFF,  1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'd9,   8'd5,   1'b0, 8'd4,   1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'd200, 8'd100, 1'b1, 8'h2D,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1, 1'b0};

        // Reset with start asserted: reset must win.
        drive(1'b1, 1'b0, 8'd3, 8'd4, 1'b0);
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.overflow, 0);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_busy", bus.busy, 0);
        held_res = '0;

        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].cin);
            for (int c = 1; c <= W; c++) begin
                check_busy_cycle($sformatf("v%0d", i), c);
                tick();
            end
            check_done($sformatf("v%0d", i), vecs[i].res, vecs[i].cout, vecs[i].ovf);
            tick();
            check($sformatf("v%0d_pulse_end", i), bus.done, 0);
        end

        // start pulsed in RUN cycle 4 with new operands must be ignored.
        launch(1'b0, 8'd100, 8'd27, 1'b0);
        for (int c = 1; c <= W; c++) begin
            if (c == 4) drive(1'b1, 1'b1, 8'd1, 8'd1, 1'b1);
            if (c == 5) drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
            check_busy_cycle("ign", c);
            tick();
        end
        check_done("ign", 8'd127, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("ign_idle_busy_%0d", c), bus.busy, 0);
            check($sformatf("ign_idle_done_%0d", c), bus.done, 0);
        end

        // start held in DONE: second operation begins immediately.
        launch(1'b1, 8'd9, 8'd5, 1'b0);
        for (int c = 1; c <= W; c++) begin
            check_busy_cycle("b2b_a", c);
            tick();
        end
        check_done("b2b_a", 8'd4, 1'b0, 1'b0);
        launch(1'b0, 8'd255, 8'd1, 1'b0);
        for (int c = 1; c <= W; c++) begin
            check_busy_cycle("b2b_b", c);
            check($sformatf("b2b_b_cout_c%0d", c), bus.cout, 0);
            tick();
        end
        check_done("b2b_b", 8'd0, 1'b1, 1'b0);
        tick();

        // Reset in RUN cycle 5 aborts with no done; a later start completes normally.
        launch(1'b0, 8'd255, 8'd255, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            check_busy_cycle("abort", c);
            tick();
        end
        check("abort_c5_cout_held", bus.cout, held_cout);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        check("abort_cout", bus.cout, 0);
        check("abort_ovf", bus.overflow, 0);
        begin
            int done_seen = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (bus.done || bus.busy) done_seen++;
            end
            check("abort_no_done", done_seen, 0);
        end
        held_res = '0;
        launch(1'b1, 8'd5, 8'd9, 1'b0);
        for (int c = 1; c <= W; c++) begin
            check_busy_cycle("post", c);
            tick();
        end
        check_done("post", 8'hFC, 1'b1, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
